peripheral_bus_arbiter: RTL and testbench



---
 rtl/peripheral_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_peripheral_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus_arbiter.sv
// peripheral_bus_arbiter: round-robin owner selection for the shared peripheral bus.
// One master owns the bus per transaction. Its strobes and payload are forwarded,
// and the slave's busy is returned to it. A hung slave is aborted after TIMEOUT_CYCLES.
// Ports:
//   clk, rst (async, active-low)
//   req_we/req_oe/req_address/req_byteSelect/req_dataWrite : packed per-master requests
//   req_busy/req_error/req_dataRead/req_grant               : per-master responses
//   peripheralBus_*                                         : forwarded bus and slave response
module peripheral_bus_arbiter #(
  parameter int unsigned REQUESTERS     = 4,
  parameter int unsigned ADDRESS_WIDTH  = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQUESTERS-1:0]               req_we,
  input  logic [REQUESTERS-1:0]               req_oe,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [REQUESTERS*4-1:0]             req_byteSelect,
  input  logic [REQUESTERS*32-1:0]            req_dataWrite,
  output logic [REQUESTERS-1:0]               req_busy,
  output logic [REQUESTERS-1:0]               req_error,
  output logic [31:0]                         req_dataRead,
  output logic [REQUESTERS-1:0]               req_grant,
  output logic                                peripheralBus_we,
  output logic                                peripheralBus_oe,
  output logic [ADDRESS_WIDTH-1:0]            peripheralBus_address,
  output logic [3:0]                          peripheralBus_byteSelect,
  output logic [31:0]                         peripheralBus_dataWrite,
  input  logic                                peripheralBus_busy,
  input  logic [31:0]                         peripheralBus_dataRead
);

  localparam int unsigned IDX_W = $clog2(REQUESTERS);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;

  logic [REQUESTERS-1:0]   req_c;
  logic                    any_req_c;
  logic [IDX_W-1:0]        winner_c;
  logic [IDX_W-1:0]        cand_c;
  logic                    found_c;
  logic                    owned_c;
  logic                    own_req_c;
  logic                    complete_c;
  logic                    abort_c;
  logic                    release_c;

  logic [ADDRESS_WIDTH-1:0] addr_a [REQUESTERS];
  logic [3:0]               bsel_a [REQUESTERS];
  logic [31:0]              wdat_a [REQUESTERS];

  // Unpack the per-master payload buses
  for (genvar i = 0; i < REQUESTERS; i++) begin : g_unpack
    assign addr_a[i] = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign bsel_a[i] = req_byteSelect[i*4 +: 4];
    assign wdat_a[i] = req_dataWrite[i*32 +: 32];
  end

  assign req_c     = req_we | req_oe;
  assign any_req_c = |req_c;

  // Round-robin search starting just after the last owner; the last owner itself is tried last
  always_comb begin
    winner_c = '0;
    cand_c   = '0;
    found_c  = 1'b0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      cand_c = IDX_W'((32'(last_q) + k) % REQUESTERS);
      if (!found_c && req_c[cand_c]) begin
        winner_c = cand_c;
        found_c  = 1'b1;
      end
    end
  end

  // Transaction status of the current owner
  always_comb begin
    owned_c    = (state_q == OWNED);
    own_req_c  = owned_c && req_c[owner_q];
    abort_c    = own_req_c && peripheralBus_busy && TIMEOUT_EN && (cnt_q == CNT_LIMIT);
    complete_c = own_req_c && !peripheralBus_busy;
    // Withdrawal releases ownership just like completion or abort
    release_c  = owned_c && (!own_req_c || complete_c || abort_c);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(REQUESTERS - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d = OWNED;
          owner_d = winner_c;
          last_d  = winner_c;
          cnt_d   = '0;
          grant_d = REQUESTERS'(1) << winner_c;
        end
      end
      OWNED: begin
        if (release_c) begin
          if (any_req_c) begin
            owner_d = winner_c;
            last_d  = winner_c;
            cnt_d   = '0;
            grant_d = REQUESTERS'(1) << winner_c;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = '0;
          end
        end else if (peripheralBus_busy && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: forwarding and owner responses are combinational from owner/state
  always_comb begin
    peripheralBus_we         = 1'b0;
    peripheralBus_oe         = 1'b0;
    peripheralBus_address    = '0;
    peripheralBus_byteSelect = '0;
    peripheralBus_dataWrite  = '0;
    req_busy                 = req_c;
    req_error                = '0;
    req_dataRead             = 32'hFFFF_FFFF;
    if (own_req_c) begin
      peripheralBus_we         = req_we[owner_q];
      peripheralBus_oe         = req_oe[owner_q];
      peripheralBus_address    = addr_a[owner_q];
      peripheralBus_byteSelect = bsel_a[owner_q];
      peripheralBus_dataWrite  = wdat_a[owner_q];
      req_busy[owner_q]        = peripheralBus_busy && !abort_c;
    end
    if (abort_c) begin
      req_error[owner_q] = 1'b1;
    end
    if (complete_c) begin
      req_dataRead = peripheralBus_dataRead;
    end
  end

  assign req_grant = grant_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter (4 masters, 24-bit address, timeout of 4 cycles).
module tb_peripheral_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_we, req_oe;
  logic [N*AW-1:0] req_address;
  logic [N*4-1:0]  req_byteSelect;
  logic [N*32-1:0] req_dataWrite;
  logic [N-1:0]    req_busy, req_error, req_grant;
  logic [31:0]     req_dataRead;
  logic            pb_we, pb_oe, pb_busy;
  logic [AW-1:0]   pb_address;
  logic [3:0]      pb_byteSelect;
  logic [31:0]     pb_dataWrite, pb_dataRead;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] addr_tbl [N];
  logic [3:0]    bsel_tbl [N];

  peripheral_bus_arbiter #(
    .REQUESTERS    (N),
    .ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .req_we                  (req_we),
    .req_oe                  (req_oe),
    .req_address             (req_address),
    .req_byteSelect          (req_byteSelect),
    .req_dataWrite           (req_dataWrite),
    .req_busy                (req_busy),
    .req_error               (req_error),
    .req_dataRead            (req_dataRead),
    .req_grant               (req_grant),
    .peripheralBus_we        (pb_we),
    .peripheralBus_oe        (pb_oe),
    .peripheralBus_address   (pb_address),
    .peripheralBus_byteSelect(pb_byteSelect),
    .peripheralBus_dataWrite (pb_dataWrite),
    .peripheralBus_busy      (pb_busy),
    .peripheralBus_dataRead  (pb_dataRead)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_oe = 4'b0011;
    pb_busy = 1'b0;
    pb_dataRead = 32'h1111_0000;
    #3;
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected %b", req_grant, 4'b0000); end
    checks++; if (pb_oe !== 1'b0) begin errors++; $display("FAIL rst_pb_oe: got %b expected %b", pb_oe, 1'b0); end
    checks++; if (req_busy !== 4'b0011) begin errors++; $display("FAIL rst_busy: got %b expected %b", req_busy, 4'b0011); end
    checks++; if (pb_address !== 24'h0) begin errors++; $display("FAIL rst_addr: got %h expected %h", pb_address, 24'h0); end
    step; step;
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL rst_hold_grant: got %b expected %b", req_grant, 4'b0000); end
    @(negedge clk);
    rst = 1'b1;
    step;
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b expected %b", req_grant, 4'b0001); end
    checks++; if (pb_oe !== 1'b1 || pb_we !== 1'b0) begin errors++; $display("FAIL first_strobes: got oe=%b we=%b expected oe=1 we=0", pb_oe, pb_we); end
    checks++; if (pb_address !== 24'h010004) begin errors++; $display("FAIL first_addr: got %h expected %h", pb_address, 24'h010004); end
    checks++; if (pb_byteSelect !== 4'h1) begin errors++; $display("FAIL first_bsel: got %h expected %h", pb_byteSelect, 4'h1); end
    checks++; if (req_dataRead !== 32'h1111_0000) begin errors++; $display("FAIL first_rdata: got %h expected %h", req_dataRead, 32'h1111_0000); end
    checks++; if (req_busy !== 4'b0010) begin errors++; $display("FAIL first_busy: got %b expected %b", req_busy, 4'b0010); end
    step;
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL second_grant: got %b expected %b", req_grant, 4'b0010); end
    checks++; if (pb_address !== 24'h020000) begin errors++; $display("FAIL second_addr: got %h expected %h", pb_address, 24'h020000); end
    req_oe = 4'b0000;
    step;
    checks++; if (req_grant !== 4'b0000 || pb_oe !== 1'b0) begin errors++; $display("FAIL reset_idle: got grant=%b oe=%b expected grant=0000 oe=0", req_grant, pb_oe); end
  endtask

  task automatic test_single_read;
    req_oe = 4'b0100;
    pb_busy = 1'b1;
    #1;
    checks++; if (req_busy !== 4'b0100) begin errors++; $display("FAIL sr_busy_n: got %b expected %b", req_busy, 4'b0100); end
    checks++; if (pb_oe !== 1'b0) begin errors++; $display("FAIL sr_idle_oe: got %b expected %b", pb_oe, 1'b0); end
    step;
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL sr_grant: got %b expected %b", req_grant, 4'b0100); end
    checks++; if (req_busy !== 4'b0100) begin errors++; $display("FAIL sr_busy_n1: got %b expected %b", req_busy, 4'b0100); end
    checks++; if (pb_address !== 24'h030000 || pb_oe !== 1'b1) begin errors++; $display("FAIL sr_fwd: got addr=%h oe=%b expected addr=030000 oe=1", pb_address, pb_oe); end
    checks++; if (req_dataRead !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sr_rdata_busy: got %h expected %h", req_dataRead, 32'hFFFF_FFFF); end
    step;
    checks++; if (req_busy !== 4'b0100) begin errors++; $display("FAIL sr_busy_n2: got %b expected %b", req_busy, 4'b0100); end
    step;
    pb_busy = 1'b0;
    pb_dataRead = 32'hA5A5_5A5A;
    #1;
    checks++; if (req_busy !== 4'b0000) begin errors++; $display("FAIL sr_busy_n3: got %b expected %b", req_busy, 4'b0000); end
    checks++; if (req_dataRead !== 32'hA5A5_5A5A) begin errors++; $display("FAIL sr_rdata: got %h expected %h", req_dataRead, 32'hA5A5_5A5A); end
    checks++; if (req_error !== 4'b0000) begin errors++; $display("FAIL sr_error: got %b expected %b", req_error, 4'b0000); end
    step;
    req_oe = 4'b0000;
    #1;
    checks++; if (pb_oe !== 1'b0) begin errors++; $display("FAIL sr_drop_oe: got %b expected %b", pb_oe, 1'b0); end
    step;
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL sr_idle: got %b expected %b", req_grant, 4'b0000); end
  endtask

  task automatic test_round_robin;
    int exp_rr [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    logic [3:0] eg;
    pb_busy = 1'b0;
    req_oe = 4'b1111;
    #1;
    checks++; if (req_busy !== 4'b1111) begin errors++; $display("FAIL rr_idle_busy: got %b expected %b", req_busy, 4'b1111); end
    for (int i = 0; i < 8; i++) begin
      step;
      pb_dataRead = 32'hC0DE_0000 + 32'(i);
      #1;
      eg = 4'b0001 << exp_rr[i];
      checks++; if (req_grant !== eg) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_grant, eg); end
      checks++; if (pb_address !== addr_tbl[exp_rr[i]]) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", i, pb_address, addr_tbl[exp_rr[i]]); end
      checks++; if (req_busy !== ~eg) begin errors++; $display("FAIL rr_busy[%0d]: got %b expected %b", i, req_busy, ~eg); end
      checks++; if (req_dataRead !== 32'hC0DE_0000 + 32'(i)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, req_dataRead, 32'hC0DE_0000 + 32'(i)); end
    end
    req_oe = 4'b0000;
    step;
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL rr_idle: got %b expected %b", req_grant, 4'b0000); end
  endtask

  task automatic test_timeout;
    pb_busy = 1'b1;
    pb_dataRead = 32'h1234_5678;
    req_oe = 4'b1010;
    #1;
    checks++; if (req_busy !== 4'b1010) begin errors++; $display("FAIL to_idle_busy: got %b expected %b", req_busy, 4'b1010); end
    for (int c = 1; c <= 4; c++) begin
      step;
      checks++; if (req_grant !== 4'b1000) begin errors++; $display("FAIL to_grant_c%0d: got %b expected %b", c, req_grant, 4'b1000); end
      checks++; if (req_error !== 4'b0000) begin errors++; $display("FAIL to_early_err_c%0d: got %b expected %b", c, req_error, 4'b0000); end
      checks++; if (req_busy !== 4'b1010) begin errors++; $display("FAIL to_busy_c%0d: got %b expected %b", c, req_busy, 4'b1010); end
    end
    step;
    checks++; if (req_error !== 4'b1000) begin errors++; $display("FAIL to_error: got %b expected %b", req_error, 4'b1000); end
    checks++; if (req_dataRead !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rdata: got %h expected %h", req_dataRead, 32'hFFFF_FFFF); end
    checks++; if (req_busy !== 4'b0010) begin errors++; $display("FAIL to_busy_abort: got %b expected %b", req_busy, 4'b0010); end
    req_oe = 4'b0010;
    step;
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL to_next_grant: got %b expected %b", req_grant, 4'b0010); end
    checks++; if (pb_address !== 24'h020000 || pb_oe !== 1'b1) begin errors++; $display("FAIL to_next_fwd: got addr=%h oe=%b expected addr=020000 oe=1", pb_address, pb_oe); end
    checks++; if (req_error !== 4'b0000) begin errors++; $display("FAIL to_err_clear: got %b expected %b", req_error, 4'b0000); end
  endtask

  task automatic test_withdrawal;
    req_oe = 4'b1010;
    step;
    checks++; if (req_busy !== 4'b1010) begin errors++; $display("FAIL wd_busy: got %b expected %b", req_busy, 4'b1010); end
    req_oe = 4'b1000;
    #1;
    checks++; if (pb_oe !== 1'b0 || pb_address !== 24'h0) begin errors++; $display("FAIL wd_drop: got oe=%b addr=%h expected oe=0 addr=000000", pb_oe, pb_address); end
    checks++; if (req_error !== 4'b0000) begin errors++; $display("FAIL wd_error: got %b expected %b", req_error, 4'b0000); end
    checks++; if (req_busy !== 4'b1000) begin errors++; $display("FAIL wd_busy_drop: got %b expected %b", req_busy, 4'b1000); end
    step;
    checks++; if (req_grant !== 4'b1000) begin errors++; $display("FAIL wd_next_grant: got %b expected %b", req_grant, 4'b1000); end
    checks++; if (pb_address !== 24'h040000 || pb_dataWrite !== 32'hD000_0003) begin errors++; $display("FAIL wd_next_fwd: got addr=%h wdata=%h expected addr=040000 wdata=d0000003", pb_address, pb_dataWrite); end
    req_oe = 4'b0000;
    step;
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL wd_idle: got %b expected %b", req_grant, 4'b0000); end
  endtask

  task automatic test_reset_mid;
    pb_busy = 1'b1;
    req_oe = 4'b0100;
    step;
    checks++; if (req_grant !== 4'b0100 || pb_oe !== 1'b1) begin errors++; $display("FAIL rm_owned: got grant=%b oe=%b expected grant=0100 oe=1", req_grant, pb_oe); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (pb_oe !== 1'b0 || pb_we !== 1'b0 || pb_address !== 24'h0 || pb_dataWrite !== 32'h0 || pb_byteSelect !== 4'h0) begin
      errors++; $display("FAIL rm_bus: got oe=%b we=%b addr=%h wdata=%h bsel=%h expected all zero", pb_oe, pb_we, pb_address, pb_dataWrite, pb_byteSelect);
    end
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL rm_grant: got %b expected %b", req_grant, 4'b0000); end
    checks++; if (req_busy !== 4'b0100) begin errors++; $display("FAIL rm_busy: got %b expected %b", req_busy, 4'b0100); end
    req_oe = 4'b1100;
    @(negedge clk);
    rst = 1'b1;
    step;
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL rm_restart: got %b expected %b", req_grant, 4'b0100); end
    checks++; if (pb_address !== 24'h030000) begin errors++; $display("FAIL rm_restart_addr: got %h expected %h", pb_address, 24'h030000); end
    req_oe = 4'b0000;
    step;
  endtask

  initial begin
    addr_tbl = '{24'h010004, 24'h020000, 24'h030000, 24'h040000};
    bsel_tbl = '{4'h1, 4'h3, 4'hC, 4'hF};
    req_we = '0;
    req_oe = '0;
    pb_busy = 1'b0;
    pb_dataRead = '0;
    for (int i = 0; i < N; i++) begin
      req_address[i*AW +: AW]   = addr_tbl[i];
      req_byteSelect[i*4 +: 4]  = bsel_tbl[i];
      req_dataWrite[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_withdrawal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
